// File: rtl/pc_next_sel.sv
// Next-PC selector: priority redirect among NSRC sources, sequential increment,
// and a one-entry pending buffer that holds a redirect arriving during stall.
module pc_next_sel #(
  parameter int                WIDTH    = 32,
  parameter int                NSRC     = 4,
  parameter int                INC      = 4,
  parameter int                ALIGN    = 2,
  parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NSRC-1:0]             src_req,
  input  logic [NSRC*WIDTH-1:0]       src_addr,
  input  logic                        stall,
  output logic [WIDTH-1:0]            pc,
  output logic [$clog2(NSRC+1)-1:0]   src_idx,
  output logic                        redirected,
  output logic                        misalign,
  output logic                        pend_valid,
  output logic                        pend_drop
);

  localparam int               IDXW       = $clog2(NSRC+1);
  localparam logic [WIDTH-1:0] ALIGN_MASK = {WIDTH{1'b1}} << ALIGN;

  logic             any_req;
  logic [IDXW-1:0]  win_idx;
  logic [WIDTH-1:0] win_addr;
  logic [WIDTH-1:0] tgt;
  logic             tgt_mis;

  logic [WIDTH-1:0] pend_addr;
  logic [IDXW-1:0]  pend_idx;
  logic             pend_mis;

  // Scan high to low so the lowest asserted index is the last (winning) write.
  always_comb begin
    any_req  = 1'b0;
    win_idx  = '0;
    win_addr = '0;
    for (int i = NSRC-1; i >= 0; i--) begin
      if (src_req[i]) begin
        any_req  = 1'b1;
        win_idx  = IDXW'(i);
        win_addr = src_addr[i*WIDTH +: WIDTH];
      end
    end
  end

  assign tgt     = win_addr & ALIGN_MASK;
  assign tgt_mis = |(win_addr & ~ALIGN_MASK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      src_idx    <= IDXW'(NSRC);
      redirected <= 1'b0;
      misalign   <= 1'b0;
      pend_valid <= 1'b0;
      pend_drop  <= 1'b0;
      pend_addr  <= '0;
      pend_idx   <= '0;
      pend_mis   <= 1'b0;
    end else begin
      pend_drop <= 1'b0;
      if (!stall) begin
        // A live request supersedes the buffer; either way the buffer empties.
        pend_valid <= 1'b0;
        if (any_req) begin
          pc         <= tgt;
          src_idx    <= win_idx;
          redirected <= 1'b1;
          misalign   <= tgt_mis;
        end else if (pend_valid) begin
          pc         <= pend_addr;
          src_idx    <= pend_idx;
          redirected <= 1'b1;
          misalign   <= pend_mis;
        end else begin
          pc         <= pc + WIDTH'(INC);
          src_idx    <= IDXW'(NSRC);
          redirected <= 1'b0;
          misalign   <= 1'b0;
        end
      end else if (any_req) begin
        pend_drop  <= pend_valid;
        pend_valid <= 1'b1;
        pend_addr  <= tgt;
        pend_idx   <= win_idx;
        pend_mis   <= tgt_mis;
      end
    end
  end

endmodule

// File: tb/tb_pc_next_sel.sv
// Bench for pc_next_sel: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model.
module tb_pc_next_sel;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [3:0]   src_req = '0;
  logic [127:0] src_addr = '0;
  logic         stall = 1'b0;
  logic [31:0]  pc;
  logic [2:0]   src_idx;
  logic         redirected, misalign, pend_valid, pend_drop;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  pc_next_sel dut (
    .clk(clk), .rst(rst), .src_req(src_req), .src_addr(src_addr), .stall(stall),
    .pc(pc), .src_idx(src_idx), .redirected(redirected), .misalign(misalign),
    .pend_valid(pend_valid), .pend_drop(pend_drop)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [31:0] m_pc, m_pa;
  int          m_idx, m_pi;
  bit          m_redir, m_mis, m_pv, m_pm, m_drop;

  function automatic int winner(input logic [3:0] r);
    for (int i = 0; i < 4; i++) if (r[i]) return i;
    return 4;
  endfunction

  function automatic logic [31:0] tgt_of(input logic [127:0] a, input int w);
    logic [31:0] t;
    t = a[w*32 +: 32];
    return (t / 4) * 4;
  endfunction

  function automatic bit mis_of(input logic [127:0] a, input int w);
    logic [31:0] t;
    t = a[w*32 +: 32];
    return (t % 4) != 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc <= 32'h0; m_idx <= 4; m_redir <= 0; m_mis <= 0;
      m_pv <= 0; m_drop <= 0; m_pa <= 0; m_pi <= 0; m_pm <= 0;
    end else begin
      m_drop <= 0;
      if (!stall) begin
        m_pv <= 0;
        if (src_req != 0) begin
          m_pc <= tgt_of(src_addr, winner(src_req)); m_idx <= winner(src_req);
          m_redir <= 1; m_mis <= mis_of(src_addr, winner(src_req));
        end else if (m_pv) begin
          m_pc <= m_pa; m_idx <= m_pi; m_redir <= 1; m_mis <= m_pm;
        end else begin
          m_pc <= m_pc + 32'd4; m_idx <= 4; m_redir <= 0; m_mis <= 0;
        end
      end else if (src_req != 0) begin
        m_drop <= m_pv; m_pv <= 1;
        m_pa <= tgt_of(src_addr, winner(src_req)); m_pi <= winner(src_req);
        m_pm <= mis_of(src_addr, winner(src_req));
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc",         64'(pc),         64'(m_pc));
      chk("src_idx",    64'(src_idx),    64'(m_idx));
      chk("redirected", 64'(redirected), 64'(m_redir));
      chk("misalign",   64'(misalign),   64'(m_mis));
      chk("pend_valid", 64'(pend_valid), 64'(m_pv));
      chk("pend_drop",  64'(pend_drop),  64'(m_drop));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst = 1'b1;
    chk_en = 1'b1;
    repeat (3) tick();
    chk("rst_pc", 64'(pc), 64'h0);
    chk("rst_idx", 64'(src_idx), 64'd4);
    chk("rst_redir", 64'(redirected), 64'd0);
    chk("rst_pv_drop", 64'({pend_valid, pend_drop, misalign}), 64'd0);
    rst = 1'b0;

    // Free-running 0 -> 4 -> 8 -> 12
    tick(); chk("seq_pc4", 64'(pc), 64'h4);
    tick(); chk("seq_pc8", 64'(pc), 64'h8);
    tick(); chk("seq_pc12", 64'(pc), 64'hC);
    chk("seq_idx", 64'(src_idx), 64'd4);
    chk("seq_redir", 64'(redirected), 64'd0);

    // Priority: lowest asserted index wins
    src_req = 4'b0110; src_addr[32 +: 32] = 32'h100; src_addr[64 +: 32] = 32'h200;
    tick();
    chk("prio_pc", 64'(pc), 64'h100);
    chk("prio_idx", 64'(src_idx), 64'd1);
    chk("prio_redir", 64'(redirected), 64'd1);

    // Misaligned target
    src_req = 4'b0001; src_addr[0 +: 32] = 32'h103;
    tick();
    chk("mis_pc", 64'(pc), 64'h100);
    chk("mis_flag", 64'(misalign), 64'd1);
    src_req = 4'b0000;
    tick();
    chk("mis_seq_pc", 64'(pc), 64'h104);
    chk("mis_clear", 64'(misalign), 64'd0);

    // Stall with two redirects: newer replaces older, one drop pulse
    stall = 1'b1; src_req = 4'b0001; src_addr[0 +: 32] = 32'h40;
    tick();
    chk("stall_hold1", 64'(pc), 64'h104);
    chk("stall_pv", 64'(pend_valid), 64'd1);
    chk("stall_nodrop", 64'(pend_drop), 64'd0);
    src_addr[0 +: 32] = 32'h80;
    tick();
    chk("stall_hold2", 64'(pc), 64'h104);
    chk("stall_drop", 64'(pend_drop), 64'd1);
    src_req = 4'b0000;
    tick();
    chk("stall_drop_end", 64'(pend_drop), 64'd0);
    stall = 1'b0;
    tick();
    chk("release_pc", 64'(pc), 64'h80);
    chk("release_idx", 64'(src_idx), 64'd0);
    chk("release_pv", 64'(pend_valid), 64'd0);

    // Wrap at 2^32
    src_req = 4'b0001; src_addr[0 +: 32] = 32'hFFFF_FFFC;
    tick();
    chk("wrap_pre", 64'(pc), 64'hFFFF_FFFC);
    src_req = 4'b0000;
    tick();
    chk("wrap_pc", 64'(pc), 64'h0);

    // Async reset while a redirect is pending
    stall = 1'b1; src_req = 4'b0010; src_addr[32 +: 32] = 32'h300;
    tick();
    chk("arst_pv_before", 64'(pend_valid), 64'd1);
    src_req = 4'b0000;
    #2 rst = 1'b1;
    #1;
    chk("arst_pc", 64'(pc), 64'h0);
    chk("arst_pv", 64'(pend_valid), 64'd0);
    chk("arst_idx", 64'(src_idx), 64'd4);
    tick();
    rst = 1'b0; stall = 1'b0;
    tick();
    chk("arst_after", 64'(pc), 64'h4);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      stall    = ($urandom_range(0, 2) == 0);
      src_req  = ($urandom_range(0, 1) == 0) ? 4'(($urandom)) : 4'b0000;
      src_addr = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 7) == 0) src_addr[0 +: 32] = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      if ($urandom_range(0, 149) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
      tick();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
